// File: rtl/data_mem_arbiter_pkg.sv
// data_mem_arbiter shared definitions.
// State encoding and requester port indices.
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LS    = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester and memory bus bundle for data_mem_arbiter.
// slave = arbiter side, master = requesters plus memory.
interface data_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req0;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  ack0;
  logic [DATA_WIDTH-1:0] rdata0;
  logic                  err0;

  logic                  req1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  ack1;
  logic [DATA_WIDTH-1:0] rdata1;
  logic                  err1;

  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_write_enable;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic                  busy;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_data_out,
    output ack0, rdata0, err0,
    output ack1, rdata1, err1,
    output mem_address, mem_write_enable,
    output mem_data_in, busy
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_data_out,
    input  ack0, rdata0, err0,
    input  ack1, rdata1, err1,
    input  mem_address, mem_write_enable,
    input  mem_data_in, busy
  );
endinterface

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick, one-hot grant.
// On contention the port that did not win last time wins.
module rr_arbiter2
  import data_mem_arbiter_pkg::*;
(
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  // Combinational grant selection
  always_comb begin
    gnt_o = 2'b00;
    if (req0_i && req1_i)
      gnt_o = (last_grant_i == PORT_LS) ? 2'b01 : 2'b10;
    else
      gnt_o = {req1_i, req0_i};
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Fetch / load-store arbiter for the shared data memory.
// IDLE -> ACCESS (one memory cycle) -> DONE (ack) -> IDLE.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int MEM_ADDR_BITS = 14
) (
  input logic               clk,
  input logic               reset,
  data_mem_arbiter_if.slave bus
);

  state_e                state_q;
  logic                  last_grant_q;
  logic                  win_q;
  logic                  we_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] mem_address_q;
  logic [DATA_WIDTH-1:0] mem_data_in_q;
  logic                  mem_we_q;
  logic                  busy_q;
  logic                  ack0_q, ack1_q;
  logic                  err0_q, err1_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  logic [1:0]            gnt;
  logic                  win_d;
  logic                  we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  err_d;
  logic [DATA_WIDTH-1:0] cap_d;

  rr_arbiter2 u_arb (
    .req0_i       (bus.req0),
    .req1_i       (bus.req1),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  // Select the winner's fields and check its address
  always_comb begin
    win_d   = gnt[1] ? PORT_LS : PORT_FETCH;
    we_d    = win_d ? bus.we1 : bus.we0;
    addr_d  = win_d ? bus.addr1 : bus.addr0;
    wdata_d = win_d ? bus.wdata1 : bus.wdata0;
    err_d   = (addr_d[1:0] != 2'b00) ||
              (|(addr_d >> MEM_ADDR_BITS));
    cap_d   = (!we_q && err_q) ? '0 : bus.mem_data_out;
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= PORT_LS;
      win_q         <= PORT_FETCH;
      we_q          <= 1'b0;
      err_q         <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_we_q      <= 1'b0;
      busy_q        <= 1'b0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      err0_q        <= 1'b0;
      err1_q        <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|gnt) begin
            state_q       <= ACCESS;
            last_grant_q  <= win_d;
            win_q         <= win_d;
            we_q          <= we_d;
            err_q         <= err_d;
            mem_address_q <= addr_d;
            mem_data_in_q <= wdata_d;
            mem_we_q      <= we_d && !err_d;
            busy_q        <= 1'b1;
          end
        end
        ACCESS: begin
          state_q  <= DONE;
          mem_we_q <= 1'b0;
          if (win_q == PORT_LS) begin
            rdata1_q <= cap_d;
            ack1_q   <= 1'b1;
            err1_q   <= err_q;
          end else begin
            rdata0_q <= cap_d;
            ack0_q   <= 1'b1;
            err0_q   <= err_q;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          err0_q  <= 1'b0;
          err1_q  <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack0             = ack0_q;
  assign bus.err0             = err0_q;
  assign bus.rdata0           = rdata0_q;
  assign bus.ack1             = ack1_q;
  assign bus.err1             = err1_q;
  assign bus.rdata1           = rdata1_q;
  assign bus.mem_address      = mem_address_q;
  assign bus.mem_write_enable = mem_we_q;
  assign bus.mem_data_in      = mem_data_in_q;
  assign bus.busy             = busy_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter.
// Includes a 4K-word async-read / sync-write memory.
module tb_data_mem_arbiter;
  logic clk;
  logic reset;
  logic fill;
  int   n_checks;
  int   n_errors;
  logic [31:0] mem [0:4095];

  data_mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  data_mem_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_ADDR_BITS(14)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_data_out = mem[bus.mem_address[13:2]];

  // Memory: pattern fill while fill is set, else sync write
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 4096; i++)
        mem[i] <= 32'hA000_0000 + i;
    end else if (bus.mem_write_enable) begin
      mem[bus.mem_address[13:2]] <= bus.mem_data_in;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic set_req(input int p, input logic r,
                         input logic we,
                         input logic [31:0] a,
                         input logic [31:0] d);
    if (p == 0) begin
      bus.req0 = r; bus.we0 = we;
      bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = we;
      bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic xact(input int p, input logic we,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      output logic [31:0] rd,
                      output logic er,
                      output int lat,
                      output int wecnt,
                      output logic [31:0] weaddr);
    logic ak;
    set_req(p, 1'b1, we, a, d);
    lat = -1; wecnt = 0; weaddr = '0;
    rd = '0; er = 1'b0;
    for (int i = 1; i <= 10 && lat < 0; i++) begin
      tick();
      if (bus.mem_write_enable) begin
        wecnt++;
        weaddr = bus.mem_address;
      end
      ak = (p == 0) ? bus.ack0 : bus.ack1;
      if (ak) begin
        lat = i;
        rd = (p == 0) ? bus.rdata0 : bus.rdata1;
        er = (p == 0) ? bus.err0 : bus.err1;
      end
    end
    set_req(p, 1'b0, 1'b0, '0, '0);
    tick();
  endtask

  logic [31:0] rd, weaddr, rd0, rd1;
  logic        er;
  int          lat, wecnt, a0, a1, both, nack, na;
  int          seq [0:7];

  initial begin
    n_checks = 0; n_errors = 0;
    fill = 1'b1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    #2;
    check("rst_ack0", {31'b0, bus.ack0}, 0);
    check("rst_ack1", {31'b0, bus.ack1}, 0);
    check("rst_busy", {31'b0, bus.busy}, 0);
    check("rst_we", {31'b0, bus.mem_write_enable}, 0);
    check("rst_maddr", bus.mem_address, 0);
    check("rst_mdin", bus.mem_data_in, 0);
    check("rst_rd0", bus.rdata0, 0);
    check("rst_rd1", bus.rdata1, 0);
    repeat (2) tick();
    fill = 1'b0;
    reset = 1'b0;
    tick();

    // Port 1 write then port 0 read-back
    xact(1, 1'b1, 32'h10, 32'hDEADBEEF,
         rd, er, lat, wecnt, weaddr);
    check("w1_lat", lat, 2);
    check("w1_err", {31'b0, er}, 0);
    check("w1_wecnt", wecnt, 1);
    check("w1_weaddr", weaddr, 32'h10);
    check("w1_mem", mem[4], 32'hDEADBEEF);
    check("w1_busy", {31'b0, bus.busy}, 0);
    xact(0, 1'b0, 32'h10, 32'h0,
         rd, er, lat, wecnt, weaddr);
    check("r0_lat", lat, 2);
    check("r0_rdata", rd, 32'hDEADBEEF);
    check("r0_err", {31'b0, er}, 0);
    check("r0_wecnt", wecnt, 0);

    // Simultaneous first requests after reset
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h0, '0);
    set_req(1, 1'b1, 1'b0, 32'h4, '0);
    a0 = -1; a1 = -1; both = 0; rd0 = '0; rd1 = '0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.ack0 && bus.ack1) both++;
      if (bus.ack0) begin
        a0 = i; rd0 = bus.rdata0;
        set_req(0, 1'b0, 1'b0, '0, '0);
      end
      if (bus.ack1) begin
        a1 = i; rd1 = bus.rdata1;
        set_req(1, 1'b0, 1'b0, '0, '0);
      end
    end
    check("sim_ack0_cyc", a0, 2);
    check("sim_ack1_cyc", a1, 5);
    check("sim_rd0", rd0, 32'hA000_0000);
    check("sim_rd1", rd1, 32'hA000_0001);
    check("sim_both", both, 0);

    // Continuous contention: grants alternate
    set_req(0, 1'b1, 1'b0, 32'h0, '0);
    set_req(1, 1'b1, 1'b0, 32'h4, '0);
    nack = 0; both = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.ack0 && bus.ack1) both++;
      na = int'(bus.ack0) + int'(bus.ack1);
      if (na != 0 && nack < 8) begin
        seq[nack] = bus.ack1 ? 1 : 0;
        nack++;
      end
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    tick();
    check("rr_nack", nack, 4);
    check("rr_g0", seq[0], 0);
    check("rr_g1", seq[1], 1);
    check("rr_g2", seq[2], 0);
    check("rr_g3", seq[3], 1);
    check("rr_both", both, 0);

    // Misaligned write on port 1
    xact(1, 1'b1, 32'h6, 32'h12345678,
         rd, er, lat, wecnt, weaddr);
    check("mis_lat", lat, 2);
    check("mis_err", {31'b0, er}, 1);
    check("mis_wecnt", wecnt, 0);
    check("mis_mem", mem[1], 32'hA000_0001);

    // Out-of-range read on port 0
    xact(0, 1'b0, 32'h0000_4000, 32'h0,
         rd, er, lat, wecnt, weaddr);
    check("oor_lat", lat, 2);
    check("oor_err", {31'b0, er}, 1);
    check("oor_rdata", rd, 32'h0);

    // Reset pulse in the middle of an ACCESS write
    set_req(0, 1'b1, 1'b1, 32'h8, 32'hCAFEF00D);
    tick();
    check("ab_we_pre", {31'b0, bus.mem_write_enable}, 1);
    #3;
    reset = 1'b1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    #1;
    check("ab_we_rst", {31'b0, bus.mem_write_enable}, 0);
    check("ab_busy_rst", {31'b0, bus.busy}, 0);
    #1;
    reset = 1'b0;
    nack = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.ack0 || bus.ack1) nack++;
    end
    check("ab_noack", nack, 0);
    check("ab_mem", mem[2], 32'hA000_0002);
    xact(0, 1'b0, 32'h8, 32'h0,
         rd, er, lat, wecnt, weaddr);
    check("ab_next_lat", lat, 2);
    check("ab_next_rd", rd, 32'hA000_0002);
    check("ab_next_err", {31'b0, er}, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
